// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, opcode constant and FSM encoding for instruction fetch
package inst_fetch_pkg;

    localparam int AddressWidth = 32;
    localparam int IDWidth      = 32;

    // RV32 JAL major opcode
    localparam logic [6:0] JalOpcode = 7'b1101111;

    typedef enum logic {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_e;

    // Sign-extended J-type immediate (byte offset, bit 0 always zero)
    function automatic logic [AddressWidth-1:0] jal_offset(input logic [IDWidth-1:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - circular instruction queue with wrap-bit full/empty detection
module inst_queue #(
    parameter int Depth = 4,
    parameter int Width = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [Width-1:0] i_wdata,
    input  logic             i_pop,
    output logic [Width-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PtrW = $clog2(Depth);

    // Pointers carry one extra wrap bit so equal indices can be told apart as full or empty
    logic [PtrW:0]      r_wr_ptr;
    logic [PtrW:0]      r_rd_ptr;
    logic [Width-1:0]   r_mem [Depth];

    logic [PtrW-1:0]    w_wr_idx;
    logic [PtrW-1:0]    w_rd_idx;

    assign w_wr_idx = r_wr_ptr[PtrW-1:0];
    assign w_rd_idx = r_rd_ptr[PtrW-1:0];

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]) && (w_wr_idx == w_rd_idx);
    assign o_rdata = r_mem[w_rd_idx];

    // Pointer update: clear wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Entry storage, zeroed on reset so the head never shows stale data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !i_clear) begin
            r_mem[w_wr_idx] <= i_wdata;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch PC, miss FSM and instruction queue front end (optional JAL predict: IF_JAL_PREDICT_EN)
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                     QueueDepth = 4,
    parameter logic [AddressWidth-1:0] ResetPC   = 32'h0
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    output logic [AddressWidth-1:0] if_icache_inst_addr_out,
    input  logic                    icache_if_miss_in,
    input  logic [IDWidth-1:0]      icache_if_inst_inst_in,
    output logic                    if_dec_valid_out,
    output logic [IDWidth-1:0]      if_dec_inst_out,
    output logic [AddressWidth-1:0] if_dec_pc_out,
    output logic                    if_dec_pred_taken_out,
    input  logic                    dec_if_ready_in,
    input  logic                    flush_in,
    input  logic [AddressWidth-1:0] flush_pc_in
);

`ifdef IF_JAL_PREDICT_EN
    localparam int EntryW = AddressWidth + IDWidth + 1;
`else
    localparam int EntryW = AddressWidth + IDWidth;
`endif

    fetch_state_e            r_state;
    logic [AddressWidth-1:0] r_pc;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_clear;
    logic                    w_empty;
    logic                    w_full;
    logic [AddressWidth-1:0] w_next_pc;
    logic [EntryW-1:0]       w_wdata;
    logic [EntryW-1:0]       w_rdata;
    logic [AddressWidth-1:0] w_head_pc;
    logic [IDWidth-1:0]      w_head_inst;
    logic                    w_unused_state;

    // The miss/fetch state is tracked for observability; push gating depends only on the miss input
    assign w_unused_state = (r_state == WAIT);

    // Full is sampled before any same-cycle pop, so a full queue never accepts a push
    assign w_push  = rdy_in & ~icache_if_miss_in & ~flush_in & ~w_full;
    assign w_pop   = rdy_in & ~flush_in & ~w_empty & dec_if_ready_in;
    assign w_clear = rdy_in & flush_in;

`ifdef IF_JAL_PREDICT_EN
    logic w_is_jal;
    logic w_head_pred;

    assign w_is_jal  = (icache_if_inst_inst_in[6:0] == JalOpcode);
    assign w_next_pc = w_is_jal ? (r_pc + jal_offset(icache_if_inst_inst_in))
                                : (r_pc + AddressWidth'(4));
    assign w_wdata   = {r_pc, icache_if_inst_inst_in, w_is_jal};
    assign {w_head_pc, w_head_inst, w_head_pred} = w_rdata;
    assign if_dec_pred_taken_out = w_head_pred & ~w_empty;
`else
    assign w_next_pc = r_pc + AddressWidth'(4);
    assign w_wdata   = {r_pc, icache_if_inst_inst_in};
    assign {w_head_pc, w_head_inst} = w_rdata;
    assign if_dec_pred_taken_out = 1'b0;
`endif

    assign if_icache_inst_addr_out = r_pc;
    assign if_dec_valid_out        = ~w_empty;
    assign if_dec_inst_out         = w_head_inst & {IDWidth{~w_empty}};
    assign if_dec_pc_out           = w_head_pc & {AddressWidth{~w_empty}};

    // Fetch FSM and PC register: flush redirects, a hit advances, a miss parks in WAIT
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= FETCH;
            r_pc    <= ResetPC;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_state <= FETCH;
                r_pc    <= flush_pc_in;
            end else begin
                r_state <= icache_if_miss_in ? WAIT : FETCH;
                if (w_push) begin
                    r_pc <= w_next_pc;
                end
            end
        end
    end

    inst_queue #(
        .Depth (QueueDepth),
        .Width (EntryW)
    ) u_queue (
        .clk     (clk_in),
        .rst_n   (rst_in),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

endmodule
